uart_alu_master: RTL
====================

# uart_alu_master

Host-side initiator for the UART ALU byte protocol. It accepts one request (operand A, operand B, opcode) over a valid/ready handshake, sends it as three bytes through the UART transmitter, then waits for the single result byte from the UART receiver. It reports the result, or a timeout, on a one-cycle response strobe. It sits between a local requester (test driver, soft controller) and a `uart_tx`/`uart_rx` pair, mirroring the ALU-side interface at the far end of the link.

## Interface
- `DATA_BITS`, 8: UART byte width and width of A, B and the result.
- `OP_BITS`, 6: opcode width; must be ≤ `DATA_BITS`.
- `TIMEOUT_CYCLES`, 50000: maximum cycles spent in WAIT_RES before giving up; must be ≥ 2.
- `i_clk` in 1: single clock; all logic on rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_req_valid` in 1: request present.
- `o_req_ready` out 1: block idle, request can be accepted.
- `i_req_a` in DATA_BITS: operand A.
- `i_req_b` in DATA_BITS: operand B.
- `i_req_op` in OP_BITS: opcode.
- `o_tx_start` out 1: one-cycle start pulse to the UART TX.
- `o_tx_data` out DATA_BITS: byte to transmit.
- `i_tx_done` in 1: UART TX finished the current byte.
- `i_rx_done` in 1: UART RX has a byte.
- `i_rx_data` in DATA_BITS: received byte.
- `o_resp_valid` out 1: one-cycle response strobe.
- `o_resp_data` out DATA_BITS: ALU result; 0 on timeout.
- `o_resp_timeout` out 1: qualifies `o_resp_valid`; 1 means no result arrived.
- `o_busy` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, SEND, WAIT_TX, WAIT_RES, RESP. A 2-bit byte index selects A, B or OP.
- **IDLE:** `o_req_ready` = 1.
  - On `i_req_valid` && `o_req_ready`: latch A, B and op; clear the index; go to SEND.
- **SEND:** `o_tx_start` = 1 for exactly one cycle. `o_tx_data` = the byte for the current index. Next state is WAIT_TX.
  - Byte order is A, B, then `{(DATA_BITS-OP_BITS)'b0, op}` (opcode zero-extended).
- **WAIT_TX:**
  - `o_tx_data` is held stable.
  - On `i_tx_done`: if index = 2, go to WAIT_RES; otherwise increment the index and go to SEND.
  - `i_tx_done` is sampled only in this state.
- **WAIT_RES:**
  - On `i_rx_done`: capture `i_rx_data`, clear the timeout flag, go to RESP.
  - Timeout counter: starts at 0 on entry and increments each cycle. At `TIMEOUT_CYCLES-1` without `i_rx_done`, set the result to 0 and the timeout flag to 1, then go to RESP.
  - If `i_rx_done` arrives on the terminal count cycle, the data wins and no timeout is reported.
- **RESP:** `o_resp_valid` = 1 for one cycle, then go to IDLE. `o_resp_data` and `o_resp_timeout` hold until the next response.
- **Ignored inputs:** `i_rx_done` outside WAIT_RES is dropped. There is no response backpressure.
- **Request operands:** sampled only at acceptance; later changes have no effect.
- **Reset (values apply from the cycle after `i_reset` is sampled high):**
  - All registered outputs = 0, state = IDLE, index = 0, counter = 0.
  - `o_req_ready` = 0 while `i_reset` = 1.
  - Reset mid-transaction aborts it: no `o_resp_valid`, and no further `o_tx_start`.

## Timing
- Acceptance at cycle 0 → `o_tx_start` (byte A) at cycle 1.
- `i_tx_done` at cycle t in WAIT_TX → next `o_tx_start` at t+1.
- Minimum spacing between start pulses is 2 cycles.
- `i_rx_done` at cycle r in WAIT_RES → `o_resp_valid` at r+1, `o_req_ready` at r+2.
- Timeout:
  - WAIT_RES entered at cycle w → `o_resp_valid` with timeout at w+TIMEOUT_CYCLES.
  - An `i_rx_done` at w+TIMEOUT_CYCLES-1 still counts as data.
- All outputs are registered except `o_req_ready` = (state==IDLE) && !`i_reset`.

## Configuration
- `UART_ALU_MASTER_TIMEOUT_EN` defined: timeout counter present, behaviour as above.
- Undefined:
  - No counter is built; WAIT_RES waits indefinitely for `i_rx_done`.
  - `o_resp_timeout` is tied to 0.
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- **Package `uart_alu_pkg`:** state encoding localparams; byte index constants IDX_A=0, IDX_B=1, IDX_OP=2; ALU opcode constants shared with the ALU side.
- **Sub-module `uart_alu_timeout`:** clear/enable/expired counter, instantiated only under `UART_ALU_MASTER_TIMEOUT_EN`.
- **Shape:** the remaining FSM, request latch and byte mux stay in one module, about 150–250 lines.

## Test plan
- **Reset:** hold `i_reset` 3 cycles mid-WAIT_TX → no `o_tx_start`, no `o_resp_valid`, all registered outputs 0; `o_req_ready` = 1 the first cycle after release.
- **Basic transaction:** A=0x05, B=0x03, op=0x20; TX model asserts done 10 cycles after each start; RX returns 0x08 → TX bytes 0x05, 0x03, 0x20 in order, one start pulse each; `o_resp_valid` one cycle with data 0x08, timeout 0.
- **Opcode zero-extension:** op=6'h3F → third TX byte 0x3F; A=0xFF, B=0x00 transmitted unchanged.
- **Stray RX byte:** `i_rx_done` with 0xAA during the B-byte WAIT_TX, then 0x11 in WAIT_RES → response data 0x11; 0xAA never reported.
- **Timeout** (`TIMEOUT_CYCLES`=16, macro defined):
  - No RX → `o_resp_valid` 16 cycles after WAIT_RES entry, data 0x00, timeout 1.
  - Rerun with `i_rx_done` = 0x42 at the terminal cycle → data 0x42, timeout 0.
- **Back-to-back requests:** `i_req_valid` held high with two requests → second accepted exactly at `o_req_ready` two cycles after the first `i_rx_done`; operand changes during busy are ignored.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU byte protocol: FSM encoding, byte-slot
// indices and the opcode set understood by the ALU at the far end of the link.
package uart_alu_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSend    = 3'd1,
    StWaitTx  = 3'd2,
    StWaitRes = 3'd3,
    StResp    = 3'd4
  } state_e;

  localparam logic [1:0] IDX_A  = 2'd0;
  localparam logic [1:0] IDX_B  = 2'd1;
  localparam logic [1:0] IDX_OP = 2'd2;

  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/uart_alu_master_if.sv
// Request, UART TX/RX and response signals of uart_alu_master. The master
// modport is the block's own view; slave is the view of its surroundings.
interface uart_alu_master_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned OP_BITS   = 6
);

  logic                 i_req_valid;
  logic                 o_req_ready;
  logic [DATA_BITS-1:0] i_req_a;
  logic [DATA_BITS-1:0] i_req_b;
  logic [OP_BITS-1:0]   i_req_op;
  logic                 o_tx_start;
  logic [DATA_BITS-1:0] o_tx_data;
  logic                 i_tx_done;
  logic                 i_rx_done;
  logic [DATA_BITS-1:0] i_rx_data;
  logic                 o_resp_valid;
  logic [DATA_BITS-1:0] o_resp_data;
  logic                 o_resp_timeout;
  logic                 o_busy;

  modport master (
    input  i_req_valid, i_req_a, i_req_b, i_req_op, i_tx_done, i_rx_done, i_rx_data,
    output o_req_ready, o_tx_start, o_tx_data, o_resp_valid, o_resp_data, o_resp_timeout,
           o_busy
  );

  modport slave (
    output i_req_valid, i_req_a, i_req_b, i_req_op, i_tx_done, i_rx_done, i_rx_data,
    input  o_req_ready, o_tx_start, o_tx_data, o_resp_valid, o_resp_data, o_resp_timeout,
           o_busy
  );

endinterface

// File: rtl/uart_alu_timeout.sv
// Cycle counter for the result wait: held at zero by i_clear, counts while
// i_enable, and flags the terminal count CYCLES-1.
module uart_alu_timeout #(
  parameter int unsigned CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(CYCLES);
  localparam logic [CntW-1:0] Last = CntW'(CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (cnt_q == Last);

endmodule

// File: rtl/uart_alu_master.sv
// Host-side initiator: sends A, B, op as three UART bytes and waits for the result byte.
// Define UART_ALU_MASTER_TIMEOUT_EN to bound the result wait to TIMEOUT_CYCLES.
module uart_alu_master
  import uart_alu_pkg::*;
#(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned OP_BITS        = 6,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic              i_clk,
  input logic              i_reset,
  uart_alu_master_if.master bus
);

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] a_q, a_d;
  logic [DATA_BITS-1:0] b_q, b_d;
  logic [OP_BITS-1:0]   op_q, op_d;
  logic                 tx_start_q, tx_start_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [DATA_BITS-1:0] resp_data_q, resp_data_d;
  logic                 busy_q, busy_d;

  function automatic logic [DATA_BITS-1:0] tx_byte(input logic [1:0]           idx,
                                                   input logic [DATA_BITS-1:0] a,
                                                   input logic [DATA_BITS-1:0] b,
                                                   input logic [OP_BITS-1:0]   op);
    case (idx)
      IDX_A:   tx_byte = a;
      IDX_B:   tx_byte = b;
      default: tx_byte = DATA_BITS'(op);
    endcase
  endfunction

`ifdef UART_ALU_MASTER_TIMEOUT_EN
  logic resp_timeout_q, resp_timeout_d;
  logic expired;

  uart_alu_timeout #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (state_q != StWaitRes),
    .i_enable  (state_q == StWaitRes),
    .o_expired (expired)
  );
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
`ifdef UART_ALU_MASTER_TIMEOUT_EN
    resp_timeout_d = resp_timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.i_req_valid) begin
          a_d        = bus.i_req_a;
          b_d        = bus.i_req_b;
          op_d       = bus.i_req_op;
          idx_d      = IDX_A;
          tx_start_d = 1'b1;
          state_d    = StSend;
        end
      end
      StSend: state_d = StWaitTx;
      StWaitTx: begin
        if (bus.i_tx_done) begin
          if (idx_q == IDX_OP) begin
            state_d = StWaitRes;
          end else begin
            idx_d      = idx_q + 2'd1;
            tx_start_d = 1'b1;
            state_d    = StSend;
          end
        end
      end
      StWaitRes: begin
        // Data on the terminal count cycle takes priority over the timeout.
        if (bus.i_rx_done) begin
          resp_data_d  = bus.i_rx_data;
          resp_valid_d = 1'b1;
          state_d      = StResp;
`ifdef UART_ALU_MASTER_TIMEOUT_EN
          resp_timeout_d = 1'b0;
        end else if (expired) begin
          resp_data_d    = '0;
          resp_timeout_d = 1'b1;
          resp_valid_d   = 1'b1;
          state_d        = StResp;
`endif
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (tx_start_d) begin
      tx_data_d = tx_byte(idx_d, a_d, b_d, op_d);
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= StIdle;
      idx_q        <= IDX_A;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
`ifdef UART_ALU_MASTER_TIMEOUT_EN
      resp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      busy_q       <= busy_d;
`ifdef UART_ALU_MASTER_TIMEOUT_EN
      resp_timeout_q <= resp_timeout_d;
`endif
    end
  end

  assign bus.o_req_ready  = (state_q == StIdle) && !i_reset;
  assign bus.o_tx_start   = tx_start_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_resp_valid = resp_valid_q;
  assign bus.o_resp_data  = resp_data_q;
  assign bus.o_busy       = busy_q;
`ifdef UART_ALU_MASTER_TIMEOUT_EN
  assign bus.o_resp_timeout = resp_timeout_q;
`else
  assign bus.o_resp_timeout = 1'b0;
`endif

endmodule
